// File: rtl/divider_seq.sv
// divider_seq: fixed-latency unsigned restoring divider, one quotient bit per cycle.
module divider_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d, rmd_q, rmd_d;
  logic [WIDTH:0]   rem_q, rem_d, r_sh, r_nx;
  logic             dbz_q, dbz_d, dbz_run_q, dbz_run_d, ge, accept, last;
  // the dividend register doubles as the quotient shift register
  assign r_sh   = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign ge     = r_sh >= {1'b0, dvs_q};
  assign r_nx   = ge ? r_sh - {1'b0, dvs_q} : r_sh;
  assign accept = start && state_q != RUN;
  assign last   = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    dbz_d     = dbz_q;
    dbz_run_d = dbz_run_q;
    if (accept) begin
      state_d   = RUN;
      dvd_d     = a;
      dvs_d     = b;
      rem_d     = '0;
      cnt_d     = '0;
      dbz_run_d = b == '0;
    end else if (state_q == RUN) begin
      rem_d = r_nx;
      dvd_d = {dvd_q[WIDTH-2:0], ge};
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        quo_d   = {dvd_q[WIDTH-2:0], ge};
        rmd_d   = r_nx[WIDTH-1:0];
        dbz_d   = dbz_run_q;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      rmd_q     <= '0;
      dbz_q     <= 1'b0;
      dbz_run_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
      dbz_q     <= dbz_d;
      dbz_run_q <= dbz_run_d;
    end
  end
  assign busy        = state_q == RUN;
  assign done        = state_q == DONE;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: random and directed checks of divider_seq against an arithmetic model.
module tb_divider_seq;
  localparam int W = 8;
  logic clk = 0, rst = 1, start = 0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  int errors = 0, checks = 0, dones = 0, exp_dones = 0;
  always #5 clk = ~clk;
  divider_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // model: an op occupies W cycles, then its result appears with done
  int left = 0;
  logic m_on = 0, ed = 0, ez = 0;
  logic [W-1:0] pa = '0, pb = '0, eq = '0, er = '0;
  always @(posedge clk) begin
    m_on = 1;
    ed = 0;
    if (rst) begin
      left = 0; eq = '0; er = '0; ez = 0;
    end else if (left > 0) begin
      left--;
      if (left == 0) begin
        ed = 1;
        ez = pb == '0;
        eq = ez ? '1 : pa / pb;
        er = ez ? pa : pa % pb;
        exp_dones++;
      end
    end else if (start) begin
      left = W; pa = a; pb = b;
    end
  end
  always @(negedge clk) if (m_on) begin
    chk("busy", int'(busy), int'(left > 0));
    chk("done", int'(done), int'(ed));
    chk("quotient", int'(quotient), int'(eq));
    chk("remainder", int'(remainder), int'(er));
    chk("div_by_zero", int'(div_by_zero), int'(ez));
    if (done) dones++;
  end
  task automatic op(input int x, input int y, input int q, input int r, input int z);
    int n = 1, nb = 0;
    start = 1; a = W'(x); b = W'(y);
    @(negedge clk);
    start = 0; a = W'($urandom); b = W'($urandom);
    while (!done && n < 3 * W) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    chk("op_latency", n, W + 1);
    chk("op_busy_cycles", nb, W);
    chk("op_quotient", int'(quotient), q);
    chk("op_remainder", int'(remainder), r);
    chk("op_div_by_zero", int'(div_by_zero), z);
  endtask
  initial begin
    int nd;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_z", int'(div_by_zero), 0);
    op(100, 7, 14, 2, 0);
    @(negedge clk);
    chk("hold_done", int'(done), 0);
    chk("hold_q", int'(quotient), 14);
    chk("hold_r", int'(remainder), 2);
    op(255, 1, 255, 0, 0);   @(negedge clk);
    op(3, 200, 0, 3, 0);     @(negedge clk);
    op(0, 9, 0, 0, 0);       @(negedge clk);
    op(255, 255, 1, 0, 0);   @(negedge clk);
    op(5, 0, 255, 5, 1);     @(negedge clk);
    op(6, 3, 2, 0, 0);
    op(50, 8, 6, 2, 0);
    @(negedge clk);
    start = 1; a = 100; b = 7;
    @(negedge clk);
    nd = 0;
    for (int n = 1; n <= 12; n++) begin
      start = n == 3;
      if (n == 3) begin a = 9; b = 9; end
      if (done) begin
        nd++;
        chk("ign_latency", n, W + 1);
        chk("ign_q", int'(quotient), 14);
        chk("ign_r", int'(remainder), 2);
      end
      @(negedge clk);
    end
    start = 0;
    chk("ign_dones", nd, 1);
    start = 1; a = 100; b = 7;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_dones", nd, 0);
    op(20, 6, 3, 2, 0);
    @(negedge clk);
    for (int i = 0; i < 30000; i++) begin
      start = $urandom_range(0, 2) == 0;
      a = W'($urandom);
      b = $urandom_range(0, 7) == 0 ? '0 : W'($urandom);
      @(negedge clk);
    end
    start = 0;
    repeat (2 * W) @(negedge clk);
    chk("done_count", dones, exp_dones);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
